mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the shared RAM/IO bus.
- Master 0 is the riscvmulti CPU port; master 1 is a secondary requester (debug loader / DMA).
- Output drives the single-port RAM and I/O decode as one bus (addr, writedata, memwrite, readdata).
- Policy: round-robin with bounded lock for atomic sequences; single-beat transfers; fixed 1-cycle read latency.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_HOLD, 4, maximum consecutive locked transfers per grant; legal range 1..16.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- m0_req  in  1  master 0 transfer request.
- m0_we  in  1  master 0 write enable.
- m0_lock  in  1  master 0 requests to keep the bus after this beat.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 owns the bus this cycle.
- m0_rvalid  out  1  master 0 read data valid.
- m0_rdata  out  DATA_W  master 0 read data.
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- s_we  out  1  slave write strobe.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_rdata  in  DATA_W  slave read data, valid one cycle after the address cycle.

Behaviour:
- States: IDLE, OWN0, OWN1. Registers: state, last (last master served), hold_cnt (4 bits), rv0, rv1, all synchronous.
- Reset (reset=0 at a clk edge):
  - state=IDLE, last=1 (so master 0 wins the first tie), hold_cnt=0, rv0=rv1=0.
  - Reset during a transfer aborts it; no rvalid is issued for it.
- Grant decode (combinational from state): m0_gnt=(state==OWN0), m1_gnt=(state==OWN1).
- Transfer (xfer_x) = gnt_x & req_x.
- Slave drive:
  - s_addr and s_wdata come from the owner.
  - s_we = xfer & owner_we.
  - In IDLE, or when the owner's req is low: s_we=0, s_addr=0, s_wdata=0.
- Read path:
  - rv_x <= xfer_x & ~we_x; m_x_rvalid = rv_x.
  - m_x_rdata = rv_x ? s_rdata : 0.
  - Writes produce no rvalid.
- IDLE transitions:
  - Only m0_req -> OWN0. Only m1_req -> OWN1.
  - Both requesting -> the master != last.
  - hold_cnt<=0.
  - Request-to-grant latency is 1 cycle from IDLE.
- OWNx transitions:
  - On xfer_x: last<=x. Stay in OWNx with hold_cnt+1 if lock_x=1 and hold_cnt<MAX_HOLD-1.
  - Release otherwise: if req_other -> OWN_other with hold_cnt<=0 (no bubble), else IDLE.
  - If req_x=0 while in OWNx: release immediately, same rule, and last is unchanged.
- Fairness:
  - Unlocked, both requesting: grants alternate every cycle (0,1,0,1...).
  - Locked: at most MAX_HOLD consecutive beats, then forced handover if the other master is requesting.
  - If the other master is idle when the limit is reached, go to IDLE and re-arbitrate next cycle; the same master may win again.
- Changes to req/we/addr/wdata while not granted have no effect.
- Masters hold their request stable until they see gnt & req.
- Back-to-back reads by one owner give rvalid on consecutive cycles.
- rvalid of one master may coincide with the other master's transfer cycle.

Test Plan:
- Reset: hold reset=0 for 2 clks with m0_req=1 -> m0_gnt=0, m1_gnt=0, s_we=0, rvalids=0. Release reset -> m0_gnt=1 one cycle later.
- Single read: m0 read at addr 0x40 with the slave returning 0xDEADBEEF -> m0_gnt in cycle 1, s_addr=0x40 in cycle 1, m0_rvalid=1 and m0_rdata=0xDEADBEEF in cycle 2, m1_rvalid=0.
- Contention: m0_req and m1_req held high, lock=0, both writing -> grants 0,1,0,1 on consecutive cycles; s_we=1 every cycle; s_wdata alternates between the two masters' data.
- Lock limit: m1_lock=1 with continuous m1 reads, m0_req high, MAX_HOLD=4 -> exactly 4 consecutive m1_gnt cycles, then m0_gnt with no idle cycle.
- Owner drop: m0 granted, m0_req falls while m1_req=1 -> next cycle m1_gnt=1, s_we=0 in the drop cycle, last stays 1.
- Mid-op reset: m1 read in flight (xfer cycle), reset=0 at the next edge -> m1_rvalid=0 and state IDLE. After release with both requesting, master 0 is granted first.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave arbiter for the shared RAM/IO bus.
// Master 0 is the CPU port; master 1 is a secondary requester (debug loader / DMA).
// Round-robin between masters. An owner may keep the bus for up to MAX_HOLD beats
// by asserting lock. Transfers are single-beat with a fixed 1-cycle read latency.
//
// Ports:
//   clk, reset           system clock; synchronous active-low reset
//   mN_req/we/lock       master N request, write enable, keep-bus-after-this-beat
//   mN_addr/wdata        master N address and write data
//   mN_gnt               master N owns the bus this cycle
//   mN_rvalid/rdata      master N read data (one cycle after its read beat)
//   s_we/addr/wdata      slave bus drive
//   s_rdata              slave read data, valid one cycle after the address cycle
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1
  } state_e;

  // hold_cnt counts locked beats already taken in this tenure beyond the first.
  localparam logic [3:0] HoldMax = 4'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] hold_q, hold_d;
  logic       rv0_q, rv1_q;

  logic xfer0, xfer1;

  assign m0_gnt = (state_q == StOwn0);
  assign m1_gnt = (state_q == StOwn1);
  assign xfer0  = m0_gnt & m0_req;
  assign xfer1  = m1_gnt & m1_req;

  // Slave bus is zero whenever no transfer is taking place.
  always_comb begin
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (xfer0) begin
      s_we    = m0_we;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
    end else if (xfer1) begin
      s_we    = m1_we;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end
  end

  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = rv0_q ? s_rdata : '0;
  assign m1_rdata  = rv1_q ? s_rdata : '0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        hold_d = '0;
        if (m0_req && m1_req) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (m0_req) begin
          state_d = StOwn0;
        end else if (m1_req) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (m0_req) begin
          last_d = 1'b0;
        end
        if (m0_req && m0_lock && (hold_q < HoldMax)) begin
          hold_d = hold_q + 4'd1;
        end else begin
          // Hand over directly when the other master waits, avoiding an idle bubble.
          state_d = m1_req ? StOwn1 : StIdle;
          hold_d  = '0;
        end
      end
      StOwn1: begin
        if (m1_req) begin
          last_d = 1'b1;
        end
        if (m1_req && m1_lock && (hold_q < HoldMax)) begin
          hold_d = hold_q + 4'd1;
        end else begin
          state_d = m0_req ? StOwn0 : StIdle;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      hold_q  <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      rv0_q   <= xfer0 & ~m0_we;
      rv1_q   <= xfer1 & ~m1_we;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by randomized
// traffic, all checked against a tenure-based behavioural model of the arbiter.
module tb_mem_bus_arbiter;

  localparam int MaxHold = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req[2];
  logic        we[2];
  logic        lock[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];
  logic        gnt[2];
  logic        rvalid[2];
  logic [31:0] rdata[2];
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the bus (-1 none), who was served last, beats served in this
  // tenure, and which master has a read response due next cycle.
  int m_owner;
  int m_last;
  int m_beats;
  bit m_pend[2];

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_HOLD(MaxHold)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .m0_req   (req[0]),
    .m0_we    (we[0]),
    .m0_lock  (lock[0]),
    .m0_addr  (addr[0]),
    .m0_wdata (wdata[0]),
    .m0_gnt   (gnt[0]),
    .m0_rvalid(rvalid[0]),
    .m0_rdata (rdata[0]),
    .m1_req   (req[1]),
    .m1_we    (we[1]),
    .m1_lock  (lock[1]),
    .m1_addr  (addr[1]),
    .m1_wdata (wdata[1]),
    .m1_gnt   (gnt[1]),
    .m1_rvalid(rvalid[1]),
    .m1_rdata (rdata[1]),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = 1;
    m_beats   = 0;
    m_pend[0] = 1'b0;
    m_pend[1] = 1'b0;
  endtask

  task automatic model_check();
    bit          act;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    act     = (m_owner >= 0) && req[m_owner];
    e_addr  = act ? addr[m_owner] : 32'h0;
    e_wdata = act ? wdata[m_owner] : 32'h0;
    for (int x = 0; x < 2; x++) begin
      chk($sformatf("m%0d_gnt", x), 64'(gnt[x]), 64'(m_owner == x));
      chk($sformatf("m%0d_rvalid", x), 64'(rvalid[x]), 64'(m_pend[x]));
      chk($sformatf("m%0d_rdata", x), 64'(rdata[x]), 64'(m_pend[x] ? s_rdata : 32'h0));
    end
    chk("s_we", 64'(s_we), 64'(act && we[m_owner]));
    chk("s_addr", 64'(s_addr), 64'(e_addr));
    chk("s_wdata", 64'(s_wdata), 64'(e_wdata));
  endtask

  task automatic model_step();
    int  o;
    bit  stay;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int x = 0; x < 2; x++) m_pend[x] = (m_owner == x) && req[x] && !we[x];
    if (m_owner < 0) begin
      if (req[0] && req[1]) m_owner = 1 - m_last;
      else if (req[0]) m_owner = 0;
      else if (req[1]) m_owner = 1;
      m_beats = 0;
    end else begin
      o    = m_owner;
      stay = 1'b0;
      if (req[o]) begin
        m_last  = o;
        m_beats = m_beats + 1;
        stay    = lock[o] && (m_beats < MaxHold);
      end
      if (!stay) begin
        m_owner = req[1-o] ? 1 - o : -1;
        m_beats = 0;
      end
    end
  endtask

  // Entered just after a falling edge with inputs already driven; leaves at the next one.
  task automatic tick();
    #2;
    model_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int x = 0; x < 2; x++) begin
      req[x]   = 1'b0;
      we[x]    = 1'b0;
      lock[x]  = 1'b0;
      addr[x]  = 32'h0;
      wdata[x] = 32'h0;
    end
    s_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst    = 1'b0;
    req[0] = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held with m0 requesting: nothing granted or strobed.
    #1;
    chk("rst_m0_gnt", 64'(gnt[0]), 64'd0);
    chk("rst_m1_gnt", 64'(gnt[1]), 64'd0);
    chk("rst_s_we", 64'(s_we), 64'd0);
    chk("rst_rvalid", 64'({rvalid[0], rvalid[1]}), 64'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_m0_gnt", 64'(gnt[0]), 64'd1);

    // Single read at 0x40; data returns the following cycle.
    addr[0] = 32'h40;
    we[0]   = 1'b0;
    #1;
    chk("rd_s_addr", 64'(s_addr), 64'h40);
    tick();
    req[0]  = 1'b0;
    s_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_m0_rvalid", 64'(rvalid[0]), 64'd1);
    chk("rd_m0_rdata", 64'(rdata[0]), 64'hDEADBEEF);
    chk("rd_m1_rvalid", 64'(rvalid[1]), 64'd0);
    tick();

    // Contention, unlocked writes: strict alternation starting with m0.
    do_reset();
    req   = '{1'b1, 1'b1};
    we    = '{1'b1, 1'b1};
    wdata = '{32'hA0A0_0000, 32'hB1B1_1111};
    tick();
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("alt_gnt0_%0d", i), 64'(gnt[0]), 64'(i % 2 == 0));
      chk($sformatf("alt_swe_%0d", i), 64'(s_we), 64'd1);
      chk($sformatf("alt_wdata_%0d", i), 64'(s_wdata), 64'(wdata[i % 2]));
      tick();
    end

    // Lock limit: m1 locked reads, m0 waiting -> exactly MaxHold m1 beats.
    do_reset();
    req[1]  = 1'b1;
    lock[1] = 1'b1;
    addr[1] = 32'h100;
    tick();
    req[0] = 1'b1;
    for (int i = 0; i < MaxHold; i++) begin
      #1;
      chk($sformatf("lock_m1_gnt_%0d", i), 64'(gnt[1]), 64'd1);
      tick();
    end
    #1;
    chk("lock_handover_m0", 64'(gnt[0]), 64'd1);
    chk("lock_handover_m1", 64'(gnt[1]), 64'd0);
    tick();

    // Owner drop: m0 lets go while m1 waits; last stays at 1.
    do_reset();
    req[0] = 1'b1;
    we[0]  = 1'b1;
    tick();
    req[0] = 1'b0;
    req[1] = 1'b1;
    #1;
    chk("drop_s_we", 64'(s_we), 64'd0);
    tick();
    chk("drop_m1_gnt", 64'(gnt[1]), 64'd1);
    req[1] = 1'b0;
    tick();
    req = '{1'b1, 1'b1};
    tick();
    chk("drop_last_m0_wins", 64'(gnt[0]), 64'd1);

    // Reset lands on an m1 read beat: no response, arbitration restarts.
    do_reset();
    req[1] = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_m1_rvalid", 64'(rvalid[1]), 64'd0);
    chk("midrst_idle", 64'({gnt[0], gnt[1]}), 64'd0);
    rst = 1'b1;
    req = '{1'b1, 1'b1};
    tick();
    chk("midrst_m0_first", 64'(gnt[0]), 64'd1);

    // Randomized traffic; lock biased high to exercise the hold limit.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) != 0);
      for (int x = 0; x < 2; x++) begin
        req[x]   = ($urandom_range(0, 3) != 0);
        we[x]    = 1'($urandom);
        lock[x]  = ($urandom_range(0, 2) != 0);
        addr[x]  = $urandom;
        wdata[x] = $urandom;
      end
      s_rdata = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
